alu_multicycle: RTL and testbench

// - Registered, handshaked successor to the combinational core ALU, parametrised in data width.
// - Adds XOR, shifts, SLT/SLTU and an optional multiplier.
// - Shifts and MUL are iterative (multi-cycle). All other ops take one cycle.
// - Sits between the decode/operand stage and the writeback stage; uses valid/ready on both sides.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_comb_unit.sv | 29 ++
 rtl/alu_multicycle.sv | 175 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Package for the multi-cycle ALU: operation encodings, FSM states and legality check.
// Honours the ALU_MUL_EN macro: when defined, the MUL encoding (1011) is legal.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_MUL  = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_DONE  = 2'd3
  } alu_state_e;

  // True for encodings the ALU executes; everything else completes as illegal.
  function automatic logic is_legal_op(logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_XOR,
      OP_SLL, OP_SRL, OP_SUB, OP_SRA,
      OP_SLT, OP_SLTU: return 1'b1;
`ifdef ALU_MUL_EN
      OP_MUL:          return 1'b1;
`endif
      default:         return 1'b0;
    endcase
  endfunction

  // Shifts are the iterative ops that step one bit per cycle.
  function automatic logic is_shift_op(logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_unit.sv
// Single-cycle ALU functions: AND/OR/XOR/ADD/SUB/SLT/SLTU.
// Shift and MUL encodings return zero here; the top handles them iteratively.
module alu_comb_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  // Pure combinational operation select; ADD/SUB wrap modulo 2^XLEN.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SLT:  y = XLEN'($signed(a) < $signed(b));
      OP_SLTU: y = XLEN'(a < b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered, valid/ready-handshaked ALU. Single-cycle ops finish in one cycle,
// shifts take one cycle per bit of shift amount, MUL is shift-add over XLEN cycles.
// Optional feature: define ALU_MUL_EN to include the multiplier (op 1011).
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal_op
);

  localparam int SHAMT_W = $clog2(XLEN);
  // One extra bit so the counter can hold XLEN for MUL.
  localparam int CNT_W   = SHAMT_W + 1;

  alu_state_e        state_q, state_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic              illegal_q, illegal_d;

  logic [XLEN-1:0]   comb_y;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]   shift_step;

`ifdef ALU_MUL_EN
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   acc_sum;
`endif

  assign shamt = in_b[SHAMT_W-1:0];

  alu_comb_unit #(.XLEN(XLEN)) u_comb (
    .op (alu_op),
    .a  (in_a),
    .b  (in_b),
    .y  (comb_y)
  );

  // One-bit shift of the working operand in the direction of the captured op.
  always_comb begin
    shift_step = opa_q;
    case (op_q)
      OP_SLL:  shift_step = {opa_q[XLEN-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, opa_q[XLEN-1:1]};
      OP_SRA:  shift_step = {opa_q[XLEN-1], opa_q[XLEN-1:1]};
      default: shift_step = opa_q;
    endcase
  end

`ifdef ALU_MUL_EN
  // Shift-add partial product: add the shifted multiplicand when the current B bit is set.
  assign acc_sum = acc_q + (opb_q[0] ? opa_q : '0);
`endif

  // FSM and datapath next-state: accept in IDLE, iterate, hold in DONE until taken.
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    illegal_d = illegal_q;
`ifdef ALU_MUL_EN
    opb_d     = opb_q;
    acc_d     = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d      = alu_op;
          illegal_d = 1'b0;
          if (!is_legal_op(alu_op)) begin
            result_d  = '0;
            illegal_d = 1'b1;
            state_d   = ST_DONE;
          end else if (is_shift_op(alu_op)) begin
            if (shamt == '0) begin
              result_d = in_a;
              state_d  = ST_DONE;
            end else begin
              opa_d   = in_a;
              cnt_d   = {1'b0, shamt};
              state_d = ST_SHIFT;
            end
`ifdef ALU_MUL_EN
          end else if (alu_op == OP_MUL) begin
            opa_d   = in_a;
            opb_d   = in_b;
            acc_d   = '0;
            cnt_d   = CNT_W'(XLEN);
            state_d = ST_MUL;
`endif
          end else begin
            result_d = comb_y;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        opa_d = shift_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = shift_step;
          state_d  = ST_DONE;
        end
      end
      ST_MUL: begin
`ifdef ALU_MUL_EN
        acc_d = acc_sum;
        opa_d = {opa_q[XLEN-2:0], 1'b0};
        opb_d = {1'b0, opb_q[XLEN-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = acc_sum;
          state_d  = ST_DONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      opa_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      opb_q     <= '0;
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
`ifdef ALU_MUL_EN
      opb_q     <= opb_d;
      acc_q     <= acc_d;
`endif
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign result     = result_q;
  assign zero       = (result_q == '0);
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (XLEN=32) against a plain-arithmetic reference model.
module tb_alu_multicycle;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;

  int errors = 0;
  int checks = 0;

  alu_multicycle #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: result, legality and latency (cycles from accept edge to out_valid sample).
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    int n;
    n   = int'(b[4:0]);
    r   = '0;
    ill = 1'b0;
    lat = 1;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a ^ b;
      4'd4:  begin r = a << n; lat = 1 + n; end
      4'd5:  begin r = a >> n; lat = 1 + n; end
      4'd6:  r = a - b;
      4'd7:  begin r = $signed(a) >>> n; lat = 1 + n; end
      4'd8:  r = {31'b0, ($signed(a) < $signed(b))};
      4'd9:  r = {31'b0, (a < b)};
`ifdef ALU_MUL_EN
      4'd11: begin r = a * b; lat = 33; end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  // Present one request while IDLE, then wait (bounded) for out_valid; leaves result uncollected.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic ill, output logic z, output int lat);
    alu_op   = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_op   = 4'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r   = result;
    ill = illegal_op;
    z   = zero;
    $display("txn op=%b a=%h b=%h result=%h illegal=%0d zero=%0d latency=%0d", op, a, b, r, ill, z, lat);
  endtask

  // Hand the result to the consumer for one cycle and return to a negedge.
  task automatic collect();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (result !== 32'h0)    begin errors++; $display("FAIL reset_result got=%h want=0", result); end
    checks++; if (zero !== 1'b1)       begin errors++; $display("FAIL reset_zero got=%b want=1", zero); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b want=0", illegal_op); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [3:0]  ops [6] = '{4'b0010, 4'b0110, 4'b1000, 4'b1001, 4'b0111, 4'b0100};
    logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] bs  [6] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h4, 32'hFFFF_FFE0};
    logic [31:0] want_r [6] = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'hF800_0000, 32'h1234_5678};
    int          want_l [6] = '{1, 1, 1, 1, 5, 1};
    logic [31:0] r;
    logic        ill, z;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i], r, ill, z, lat);
      checks++; if (r !== want_r[i]) begin errors++; $display("FAIL directed%0d_result got=%h want=%h", i, r, want_r[i]); end
      checks++; if (lat != want_l[i]) begin errors++; $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, want_l[i]); end
      checks++; if (ill !== 1'b0) begin errors++; $display("FAIL directed%0d_illegal got=%b want=0", i, ill); end
      checks++; if (z !== (want_r[i] == 32'h0)) begin errors++; $display("FAIL directed%0d_zero got=%b want=%b", i, z, (want_r[i] == 32'h0)); end
      collect();
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b, r, er;
    logic        ill, eill, z;
    int          lat, elat;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 0) b = b & 32'hFFFF_FFE7;
      model(op, a, b, er, eill, elat);
      issue(op, a, b, r, ill, z, lat);
      checks++; if (r !== er) begin errors++; $display("FAIL random%0d_result op=%b got=%h want=%h", i, op, r, er); end
      checks++; if (ill !== eill) begin errors++; $display("FAIL random%0d_illegal op=%b got=%b want=%b", i, op, ill, eill); end
      checks++; if (lat != elat) begin errors++; $display("FAIL random%0d_latency op=%b got=%0d want=%0d", i, op, lat, elat); end
      checks++; if (z !== (er == 32'h0)) begin errors++; $display("FAIL random%0d_zero got=%b want=%b", i, z, (er == 32'h0)); end
      collect();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    logic        ill, z;
    int          lat;
    issue(4'b0011, 32'hA5A5_0F0F, 32'h0F0F_FFFF, r, ill, z, lat);
    checks++; if (r !== 32'hAAAA_F0F0) begin errors++; $display("FAIL bp_result got=%h want=aaaaf0f0", r); end
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      alu_op   = 4'b0010;
      in_a     = $urandom;
      in_b     = $urandom;
      @(negedge clk);
      checks++; if (result !== 32'hAAAA_F0F0) begin errors++; $display("FAIL bp_hold%0d_result got=%h want=aaaaf0f0", c, result); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_in_ready got=%b want=0", c, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d_out_valid got=%b want=1", c, out_valid); end
    end
    in_valid = 1'b0;
    collect();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_after_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_illegal();
    logic [3:0]  ops [3] = '{4'b1111, 4'b1100, 4'b1010};
    logic [31:0] r;
    logic        ill, z;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      issue(4'b0001, 32'h0000_00F0, 32'h0000_000F, r, ill, z, lat);
      collect();
      issue(ops[i], 32'hDEAD_BEEF, 32'h1234_5678, r, ill, z, lat);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL illegal%0d_result got=%h want=0", i, r); end
      checks++; if (z !== 1'b1) begin errors++; $display("FAIL illegal%0d_zero got=%b want=1", i, z); end
      checks++; if (ill !== 1'b1) begin errors++; $display("FAIL illegal%0d_flag got=%b want=1", i, ill); end
      checks++; if (lat != 1) begin errors++; $display("FAIL illegal%0d_latency got=%0d want=1", i, lat); end
      collect();
    end
    issue(4'b0010, 32'h0000_0003, 32'h0000_0004, r, ill, z, lat);
    checks++; if (r !== 32'h7) begin errors++; $display("FAIL illegal_recover_result got=%h want=7", r); end
    checks++; if (ill !== 1'b0) begin errors++; $display("FAIL illegal_recover_flag got=%b want=0", ill); end
    collect();
  endtask

  task automatic test_reset_midop();
    logic [31:0] r;
    logic        ill, z;
    int          lat;
    issue(4'b0010, 32'h5, 32'h6, r, ill, z, lat);
    collect();
    alu_op   = 4'b0101;
    in_a     = 32'hFFFF_0000;
    in_b     = 32'd20;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midop_busy_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midop_busy_in_ready got=%b want=0", in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midop_rst_out_valid got=%b want=0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL midop_rst_result got=%h want=0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL midop_rst_zero got=%b want=1", zero); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midop_rst_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midop_discard_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midop_release_in_ready got=%b want=1", in_ready); end
    issue(4'b0101, 32'hFFFF_0000, 32'd4, r, ill, z, lat);
    checks++; if (r !== 32'h0FFF_F000) begin errors++; $display("FAIL midop_after_result got=%h want=0ffff000", r); end
    checks++; if (lat != 5) begin errors++; $display("FAIL midop_after_latency got=%0d want=5", lat); end
    collect();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_op    = 4'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
